// File: rtl/fs_rate_monitor.sv
// fs_rate_monitor: brings the divided audio sample clock into the clk domain, emits sample ticks,
// measures each half-period and tracks lock. Optional macro FS_TICK_GATE_EN gates sample_tick to lock.
module fs_rate_monitor #(
    parameter int HALF_EXP = 1134,
    parameter int TOL      = 4,
    parameter int LOCK_N   = 4,
    parameter int TIMEOUT  = 4096,
    parameter int CNT_W    = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_clk_in,
    output logic             sample_tick,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout,
    output logic [7:0]       err_count
);
    localparam int                GOOD_W   = $clog2(LOCK_N + 1);
    localparam int                CW1      = CNT_W + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [GOOD_W-1:0] LOCK_CNT = GOOD_W'(LOCK_N);
    localparam logic signed [CNT_W:0] HALF_S = CW1'(HALF_EXP);
    localparam logic signed [CNT_W:0] TOL_S  = CW1'(TOL);

    typedef enum logic [1:0] {ACQ, TRACK, LOCKED} state_t;

    state_t             state, state_nx;
    logic               ff1, ff2, ff3;
    logic [CNT_W-1:0]   cnt;
    logic [GOOD_W-1:0]  good_cnt, good_nx;
    logic               edge_det, rise, meas_ok, tick_nx, pv_nx, to_nx;
    logic [CNT_W-1:0]   meas, hp_nx;
    logic [7:0]         err_nx;

    // Signed difference so measurements below the nominal value are judged symmetrically.
    function automatic logic in_tol_f(input logic [CNT_W-1:0] m);
        logic signed [CNT_W:0] diff;
        diff = $signed({1'b0, m}) - HALF_S;
        if (diff < 0) diff = -diff;
        return diff <= TOL_S;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ACQ;
        else       state <= state_nx;
    end

    always_comb begin
        edge_det = ff2 ^ ff3;
        rise     = ff2 & ~ff3;
        meas     = cnt + 1'b1;
        meas_ok  = in_tol_f(meas);
        state_nx = state;
        good_nx  = good_cnt;
        hp_nx    = half_period;
        pv_nx    = 1'b0;
        to_nx    = 1'b0;
        err_nx   = err_count;
`ifdef FS_TICK_GATE_EN
        tick_nx  = rise && (state == LOCKED);
`else
        tick_nx  = rise;
`endif
        case (state)
            ACQ: begin
                if (edge_det) begin
                    state_nx = TRACK;
                    good_nx  = '0;
                end
            end
            TRACK, LOCKED: begin
                if (edge_det) begin
                    hp_nx = meas;
                    pv_nx = 1'b1;
                    if (meas_ok) begin
                        if (state == TRACK) begin
                            good_nx = good_cnt + 1'b1;
                            if (good_nx == LOCK_CNT) state_nx = LOCKED;
                        end
                    end else begin
                        state_nx = TRACK;
                        good_nx  = '0;
                        err_nx   = sat_inc8(err_count);
                    end
                end else if (cnt == TO_LAST) begin
                    // Edge in the same cycle takes priority, so only reached without one.
                    to_nx    = 1'b1;
                    state_nx = ACQ;
                    good_nx  = '0;
                end
            end
            default: begin
                state_nx = ACQ;
                good_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ff1          <= 1'b0;
            ff2          <= 1'b0;
            ff3          <= 1'b0;
            cnt          <= '0;
            good_cnt     <= '0;
            half_period  <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            err_count    <= 8'd0;
            locked       <= 1'b0;
            sample_tick  <= 1'b0;
        end else begin
            ff1          <= s_clk_in;
            ff2          <= ff1;
            ff3          <= ff2;
            if (edge_det)            cnt <= '0;
            else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            good_cnt     <= good_nx;
            half_period  <= hp_nx;
            period_valid <= pv_nx;
            timeout      <= to_nx;
            err_count    <= err_nx;
            locked       <= (state_nx == LOCKED);
            sample_tick  <= tick_nx;
        end
    end
endmodule

// File: tb/tb_fs_rate_monitor.sv
// Bench for fs_rate_monitor: drives sample-clock half-periods and compares against an
// edge-level reference model of lock, measurement, error and timeout behaviour.
module tb_fs_rate_monitor;
    localparam int HALF_EXP = 1134;
    localparam int TOL      = 4;
    localparam int LOCK_N   = 4;
    localparam int TIMEOUT  = 4096;
    localparam int CNT_W    = 13;

    logic             clk = 1'b0;
    logic             reset;
    logic             s_clk_in;
    logic             sample_tick;
    logic [CNT_W-1:0] half_period;
    logic             period_valid;
    logic             locked;
    logic             timeout;
    logic [7:0]       err_count;

    fs_rate_monitor #(
        .HALF_EXP(HALF_EXP), .TOL(TOL), .LOCK_N(LOCK_N), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .s_clk_in(s_clk_in), .sample_tick(sample_tick),
        .half_period(half_period), .period_valid(period_valid), .locked(locked),
        .timeout(timeout), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef enum {M_ACQ, M_TRACK, M_LOCKED} mstate_t;
    mstate_t          m_st;
    int               m_good;
    logic [7:0]       m_err;
    logic [CNT_W-1:0] m_hp;
    logic             e_pv, e_tick;
    int               since, cyc;

    logic             o_pv, o_tick, o_locked, to_locked;
    logic [CNT_W-1:0] o_hp, to_hp;
    logic [7:0]       o_err;
    int stray_pv, stray_tick, to_seen, to_exp, to_since, tick_last, tick_prev;

    // One clk cycle; is_edge marks the cycle where a toggle made 3 cycles ago is visible.
    task automatic tick_cycle(input bit is_edge);
        int d;
        @(negedge clk);
        cyc++;
        since++;
        if (is_edge) begin
            e_tick = s_clk_in;
`ifdef FS_TICK_GATE_EN
            e_tick = e_tick && (m_st == M_LOCKED);
`endif
            e_pv = 1'b0;
            if (m_st == M_ACQ) begin
                m_st = M_TRACK;
                m_good = 0;
            end else begin
                d = since - HALF_EXP;
                if (d < 0) d = -d;
                m_hp = CNT_W'(since);
                e_pv = 1'b1;
                if (d <= TOL) begin
                    if (m_st == M_TRACK) begin
                        m_good++;
                        if (m_good == LOCK_N) m_st = M_LOCKED;
                    end
                end else begin
                    m_st = M_TRACK;
                    m_good = 0;
                    if (m_err != 8'd255) m_err++;
                end
            end
            since    = 0;
            o_pv     = period_valid;
            o_tick   = sample_tick;
            o_hp     = half_period;
            o_locked = locked;
            o_err    = err_count;
            if (sample_tick) begin
                tick_prev = tick_last;
                tick_last = cyc;
            end
        end else begin
            if (m_st != M_ACQ && since == TIMEOUT) begin
                m_st = M_ACQ;
                m_good = 0;
                to_exp++;
            end
            if (period_valid) stray_pv++;
            if (sample_tick) stray_tick++;
        end
        if (timeout) begin
            to_seen++;
            to_since  = since;
            to_locked = locked;
            to_hp     = half_period;
        end
    endtask

    // Toggle s_clk_in g cycles after the previous toggle, returning at its detection cycle.
    task automatic step(input int g);
        for (int i = 0; i < g - 3; i++) tick_cycle(1'b0);
        s_clk_in = ~s_clk_in;
        tick_cycle(1'b0);
        tick_cycle(1'b0);
        tick_cycle(1'b1);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        s_clk_in = 1'b0;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        m_st   = M_ACQ;
        m_good = 0;
        m_err  = 8'd0;
        m_hp   = '0;
        since  = 0;
    endtask

    task automatic clear_stats();
        stray_pv = 0; stray_tick = 0; to_seen = 0; to_exp = 0; to_since = -1;
        tick_last = 0; tick_prev = 0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        s_clk_in = 1'b0;
        repeat (2) @(negedge clk);
        n_checks += 6;
        if (sample_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", sample_tick); end
        if (half_period !== '0) begin n_fail++; $display("FAIL reset_hp: got %0d want 0", half_period); end
        if (period_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pv: got %b want 0", period_valid); end
        if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
        if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err: got %0d want 0", err_count); end
        do_reset();
        clear_stats();
    endtask

    task automatic test_ideal();
        for (int k = 1; k <= 7; k++) begin
            step(HALF_EXP);
            n_checks += 5;
            if (o_locked !== (k >= 5)) begin n_fail++; $display("FAIL ideal_locked edge %0d: got %b want %b", k, o_locked, k >= 5); end
            if (o_pv !== (k >= 2)) begin n_fail++; $display("FAIL ideal_pv edge %0d: got %b want %b", k, o_pv, k >= 2); end
            if (o_hp !== ((k >= 2) ? 13'd1134 : 13'd0)) begin n_fail++; $display("FAIL ideal_hp edge %0d: got %0d", k, o_hp); end
            if (o_err !== 8'd0) begin n_fail++; $display("FAIL ideal_err edge %0d: got %0d want 0", k, o_err); end
            if (o_tick !== e_tick) begin n_fail++; $display("FAIL ideal_tick edge %0d: got %b want %b", k, o_tick, e_tick); end
        end
`ifndef FS_TICK_GATE_EN
        n_checks++;
        if (tick_last - tick_prev != 2 * HALF_EXP) begin
            n_fail++; $display("FAIL ideal_tick_spacing: got %0d want %0d", tick_last - tick_prev, 2 * HALF_EXP);
        end
`endif
        n_checks += 2;
        if (stray_pv != 0) begin n_fail++; $display("FAIL ideal_pv_width: got %0d extra cycles want 0", stray_pv); end
        if (stray_tick != 0) begin n_fail++; $display("FAIL ideal_tick_width: got %0d extra cycles want 0", stray_tick); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 500; i++) tick_cycle(1'b0);
        #2 reset = 1'b1;
        #1;
        n_checks += 6;
        if (sample_tick !== 1'b0) begin n_fail++; $display("FAIL midreset_tick: got %b want 0", sample_tick); end
        if (half_period !== '0) begin n_fail++; $display("FAIL midreset_hp: got %0d want 0", half_period); end
        if (period_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_pv: got %b want 0", period_valid); end
        if (locked !== 1'b0) begin n_fail++; $display("FAIL midreset_locked: got %b want 0", locked); end
        if (timeout !== 1'b0) begin n_fail++; $display("FAIL midreset_timeout: got %b want 0", timeout); end
        if (err_count !== 8'd0) begin n_fail++; $display("FAIL midreset_err: got %0d want 0", err_count); end
        do_reset();
        clear_stats();
        for (int k = 1; k <= 5; k++) begin
            step(HALF_EXP);
            n_checks++;
            if (o_locked !== (k == 5)) begin n_fail++; $display("FAIL relock edge %0d: got %b want %b", k, o_locked, k == 5); end
        end
    endtask

    task automatic test_jitter();
        logic [CNT_W-1:0] want;
        int g;
        for (int k = 0; k < 4; k++) begin
            g = (k % 2 == 0) ? 1131 : 1137;
            want = CNT_W'(g);
            step(g);
            n_checks += 3;
            if (o_locked !== 1'b1) begin n_fail++; $display("FAIL jitter_locked %0d: got %b want 1", g, o_locked); end
            if (o_hp !== want) begin n_fail++; $display("FAIL jitter_hp: got %0d want %0d", o_hp, want); end
            if (o_pv !== 1'b1) begin n_fail++; $display("FAIL jitter_pv: got %b want 1", o_pv); end
        end
        step(1150);
        n_checks += 3;
        if (o_locked !== 1'b0) begin n_fail++; $display("FAIL jump_locked: got %b want 0", o_locked); end
        if (o_err !== 8'd1) begin n_fail++; $display("FAIL jump_err: got %0d want 1", o_err); end
        if (o_hp !== 13'd1150) begin n_fail++; $display("FAIL jump_hp: got %0d want 1150", o_hp); end
        for (int k = 1; k <= 4; k++) begin
            step(HALF_EXP);
            n_checks++;
            if (o_locked !== (k == 4)) begin n_fail++; $display("FAIL jump_relock %0d: got %b want %b", k, o_locked, k == 4); end
        end
    endtask

    task automatic test_timeout();
        clear_stats();
        step(TIMEOUT + 900);
        n_checks += 6;
        if (to_seen != 1) begin n_fail++; $display("FAIL timeout_count: got %0d want 1", to_seen); end
        if (to_since != TIMEOUT) begin n_fail++; $display("FAIL timeout_delay: got %0d want %0d", to_since, TIMEOUT); end
        if (to_locked !== 1'b0) begin n_fail++; $display("FAIL timeout_locked: got %b want 0", to_locked); end
        if (to_hp !== 13'd1134) begin n_fail++; $display("FAIL timeout_hp: got %0d want 1134", to_hp); end
        if (o_pv !== 1'b0) begin n_fail++; $display("FAIL timeout_acq_pv: got %b want 0", o_pv); end
        if (o_hp !== 13'd1134) begin n_fail++; $display("FAIL timeout_acq_hp: got %0d want 1134", o_hp); end
        step(HALF_EXP);
        n_checks += 2;
        if (o_pv !== 1'b1) begin n_fail++; $display("FAIL timeout_track_pv: got %b want 1", o_pv); end
        if (o_locked !== 1'b0) begin n_fail++; $display("FAIL timeout_track_locked: got %b want 0", o_locked); end
        step(TIMEOUT);
        n_checks += 4;
        if (to_seen != 1) begin n_fail++; $display("FAIL edge_wins_count: got %0d want 1", to_seen); end
        if (o_pv !== 1'b1) begin n_fail++; $display("FAIL edge_wins_pv: got %b want 1", o_pv); end
        if (o_hp !== 13'd4096) begin n_fail++; $display("FAIL edge_wins_hp: got %0d want 4096", o_hp); end
        if (o_err !== 8'd2) begin n_fail++; $display("FAIL edge_wins_err: got %0d want 2", o_err); end
        step(TIMEOUT + 1);
        n_checks += 3;
        if (to_seen != 2) begin n_fail++; $display("FAIL late_edge_count: got %0d want 2", to_seen); end
        if (to_since != TIMEOUT) begin n_fail++; $display("FAIL late_edge_delay: got %0d want %0d", to_since, TIMEOUT); end
        if (o_pv !== 1'b0) begin n_fail++; $display("FAIL late_edge_pv: got %b want 0", o_pv); end
    endtask

    task automatic test_out_of_tol();
        do_reset();
        clear_stats();
        for (int k = 1; k <= 4; k++) begin
            step(1140);
            if (k >= 2) begin
                n_checks += 3;
                if (o_locked !== 1'b0) begin n_fail++; $display("FAIL oot_locked %0d: got %b want 0", k, o_locked); end
                if (o_hp !== 13'd1140) begin n_fail++; $display("FAIL oot_hp %0d: got %0d want 1140", k, o_hp); end
                if (o_err !== 8'(k - 1)) begin n_fail++; $display("FAIL oot_err %0d: got %0d want %0d", k, o_err, k - 1); end
            end
        end
        for (int k = 0; k < 254; k++) begin
            step(20);
            n_checks++;
            if (o_err !== m_err) begin n_fail++; $display("FAIL oot_err_run %0d: got %0d want %0d", k, o_err, m_err); end
        end
        n_checks += 2;
        if (o_err !== 8'd255) begin n_fail++; $display("FAIL oot_err_sat: got %0d want 255", o_err); end
        if (o_locked !== 1'b0) begin n_fail++; $display("FAIL oot_final_locked: got %b want 0", o_locked); end
    endtask

    task automatic test_random();
        int bnd [4];
        int r, g;
        bnd = '{1128, 1129, 1139, 1140};
        do_reset();
        clear_stats();
        for (int k = 0; k < 24; k++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      g = $urandom_range(1130, 1138);
            else if (r < 8) g = $urandom_range(10, 400);
            else            g = bnd[$urandom_range(0, 3)];
            step(g);
            n_checks += 5;
            if (o_pv !== e_pv) begin n_fail++; $display("FAIL rand_pv gap %0d: got %b want %b", g, o_pv, e_pv); end
            if (o_hp !== m_hp) begin n_fail++; $display("FAIL rand_hp gap %0d: got %0d want %0d", g, o_hp, m_hp); end
            if (o_locked !== (m_st == M_LOCKED)) begin n_fail++; $display("FAIL rand_locked gap %0d: got %b want %b", g, o_locked, m_st == M_LOCKED); end
            if (o_err !== m_err) begin n_fail++; $display("FAIL rand_err gap %0d: got %0d want %0d", g, o_err, m_err); end
            if (o_tick !== e_tick) begin n_fail++; $display("FAIL rand_tick gap %0d: got %b want %b", g, o_tick, e_tick); end
        end
        n_checks += 3;
        if (stray_pv != 0) begin n_fail++; $display("FAIL rand_pv_width: got %0d extra want 0", stray_pv); end
        if (stray_tick != 0) begin n_fail++; $display("FAIL rand_tick_width: got %0d extra want 0", stray_tick); end
        if (to_seen != to_exp) begin n_fail++; $display("FAIL rand_timeouts: got %0d want %0d", to_seen, to_exp); end
    endtask

    initial begin
        cyc = 0;
        since = 0;
        clear_stats();
        test_reset();
        test_ideal();
        test_reset_mid();
        test_jitter();
        test_timeout();
        test_out_of_tol();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
